uart_mem_loader: RTL
====================

Name: uart_mem_loader

Overview:
- Receives a length-prefixed byte stream on a UART RX line and writes the payload sequentially into byte-addressed SPRAM through the `mem` byte interface, starting at address 0.
- Counterpart to the memory-to-UART dump path. Used at boot to load memory contents from a host before the run logic starts.
- Sits between the board RX pin and the `mem` instance. `load_done` gates downstream logic.

Parameters:
- CLK_FREQ, 12_000_000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; must be ≥ 4).
- ADDR_W, 15, memory byte-address width. Capacity = 2**ADDR_W bytes.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  UART RX pin, asynchronous, idle high, 8N1 framing.
- start  in  1  one-cycle pulse. Re-arms the loader from DONE or ERROR. Ignored in all other states.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_write  out  1  write strobe. The memory stores mem_data_in at mem_addr on the clk edge where mem_write=1.
- mem_data_in  out  8  byte to be written.
- busy  out  1  high while in LEN_LO/LEN_HI/DATA after at least one byte of the current load has been received.
- load_done  out  1  high in DONE.
- load_err  out  1  high in ERROR.

Behaviour:
- Reset values: state=LEN_LO, mem_addr=0, mem_write=0, mem_data_in=0, busy=0, load_done=0, load_err=0, length=0, count=0.
- Reset mid-frame aborts the current byte and the load. Bytes already written are not undone.
- RX front end (sub-module):
  - 2-FF synchronizer on rx, reset to 1.
  - IDLE: a low level starts the half-bit timer.
  - At mid start bit, a high level returns to IDLE (glitch rejected) without pulsing.
  - Sample 8 data bits, LSB first, at the middle of each bit (every CLKS_PER_BIT cycles).
  - Check the stop bit at its middle.
  - Emit a one-cycle pulse: rx_valid with rx_data, or rx_ferr when the stop bit is 0.
  - Return to IDLE right after the stop-bit sample; a back-to-back start bit is accepted.
- Loader FSM; acts only on rx_valid / rx_ferr pulses:
  - LEN_LO: rx_valid → length[7:0]=rx_data, busy=1, go LEN_HI.
  - LEN_HI: rx_valid → length[15:8]=rx_data, count=0.
    - length==0 → DONE.
    - length > 2**ADDR_W → ERROR.
    - Otherwise → DATA.
  - DATA, on rx_valid, in the next cycle:
    - mem_write=1, mem_addr=count[ADDR_W-1:0], mem_data_in=rx_data, count+=1.
    - mem_write is exactly one cycle wide.
    - When count+1==length: enter DONE in the same cycle the write is issued. load_done rises on the following edge, i.e. one cycle after the final write strobe.
  - DONE: load_done=1, busy=0. Further RX bytes are ignored. start → clear load_done, go LEN_LO.
  - ERROR: load_err=1, busy=0, mem_write=0. RX ignored. start → clear load_err, go LEN_LO.
  - rx_ferr in LEN_LO, LEN_HI or DATA → ERROR. The bad byte is not written.
  - mem_write is 0 in every state except the single write cycle.
  - mem_addr holds its last value between writes.
- Width rules:
  - length and count are 16 bits.
  - length == 2**ADDR_W (32768) is legal and fills the whole memory. Addresses 0..32767, no wrap.
- Simultaneous events: start together with rx_valid in DONE or ERROR → start wins. The loader goes to LEN_LO and that byte is discarded.

Decomposition:
- Package uart_mem_pkg:
  - State encoding localparams: LEN_LO, LEN_HI, DATA, DONE, ERROR.
  - RX sub-state localparams: IDLE, START, BITS, STOP.
  - Function clks_per_bit(CLK_FREQ, BAUD).
- One sub-module: uart_rx (parameters CLK_FREQ, BAUD; ports clk, rst, rx, rx_valid, rx_data, rx_ferr). Mirrors the existing uart_tx.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000 → 10 clks/bit):
- Send 0x04 0x00 'A' 'B' 'C' 'D'. Expect:
  - 4 single-cycle mem_write pulses: (0,0x41), (1,0x42), (2,0x43), (3,0x44).
  - load_done=1 one cycle after the 4th pulse.
  - A model memory reads back "ABCD".
- Send 0x00 0x00 → load_done=1, no mem_write pulse. Then send 0x55 → no write. Pulse start, send 0x01 0x00 0x7E → write (0,0x7E), load_done.
- Send 0x01 0x81 (length 0x8101 > 32768) → load_err=1, no writes. start → load_err=0, FSM back in LEN_LO.
- Send 0x02 0x00, 0x11, then a byte with stop bit 0 → one write (0,0x11), then load_err=1; the bad byte is not written.
- 3-cycle low glitch on rx while idle → no rx_valid, state unchanged. Then assert rst mid-byte during a DATA load → all outputs at reset values, next stream loads from address 0.
- Length 0x8000 streamed back-to-back (no idle between frames) → 32768 writes, last at address 0x7FFF, no dropped byte, load_done=1.

Source files
------------

// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared state encodings and baud helper for the UART memory loader.
// Contents: ld_state_t (loader FSM states), rx_state_t (receiver states), clks_per_bit().
package uart_mem_pkg;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERROR} ld_state_t;
  typedef enum logic [1:0] {IDLE, START, BITS, STOP} rx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and start-bit glitch rejection.
// Ports: clk, rst (async, active-high), rx (async line, idle high),
//        rx_valid (1-cycle pulse with rx_data), rx_data[7:0], rx_ferr (1-cycle pulse, bad stop bit).
module uart_rx import uart_mem_pkg::*; #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  rx_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic [1:0] sync_q;
  logic valid_q, valid_d, ferr_q, ferr_d, s, tick;
  assign s = sync_q[1];
  assign tick = cnt_q == '0;
  always_comb begin
    st_d = st_q;
    cnt_d = tick ? cnt_q : cnt_q - 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    unique case (st_q)
      IDLE: if (!s) begin
        st_d = START;
        cnt_d = HALF;
      end
      START: if (tick) begin
        // a line that is high again at mid start bit was only a glitch
        st_d = s ? IDLE : BITS;
        cnt_d = FULL;
        idx_d = '0;
      end
      BITS: if (tick) begin
        sh_d = {s, sh_q[7:1]};
        cnt_d = FULL;
        idx_d = idx_q + 1'b1;
        st_d = idx_q == 3'd7 ? STOP : BITS;
      end
      STOP: if (tick) begin
        valid_d = s;
        ferr_d = !s;
        st_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= 2'b11;
      st_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      st_q <= st_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  assign rx_valid = valid_q;
  assign rx_data = sh_q;
  assign rx_ferr = ferr_q;
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: loads a 16-bit length-prefixed UART byte stream into byte memory from address 0.
// Ports: clk, rst (async, active-high), rx (UART line), start (re-arm pulse from DONE/ERROR),
//        mem_addr/mem_write/mem_data_in (byte write port), busy, load_done, load_err (status).
module uart_mem_loader import uart_mem_pkg::*; #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD = 9600,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [7:0]        mem_data_in,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);
  localparam int CAP = 1 << ADDR_W;
  logic rx_valid, rx_ferr;
  logic [7:0] rx_data;
  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferr(rx_ferr)
  );
  ld_state_t st_q, st_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d, len_full;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  assign len_full = {rx_data, len_q[7:0]};
  always_comb begin
    st_d = st_q;
    len_d = len_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    wr_d = 1'b0;
    unique case (st_q)
      LEN_LO: if (rx_ferr) st_d = ERROR;
        else if (rx_valid) begin
          len_d[7:0] = rx_data;
          st_d = LEN_HI;
        end
      LEN_HI: if (rx_ferr) st_d = ERROR;
        else if (rx_valid) begin
          len_d = len_full;
          cnt_d = '0;
          st_d = len_full == 16'd0 ? DONE : {16'd0, len_full} > 32'(CAP) ? ERROR : DATA;
        end
      DATA: if (rx_ferr) st_d = ERROR;
        else if (rx_valid) begin
          wr_d = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = rx_data;
          cnt_d = cnt_q + 16'd1;
          st_d = cnt_d == len_q ? DONE : DATA;
        end
      DONE, ERROR: if (start) st_d = LEN_LO;
    endcase
    busy_d = st_d == LEN_HI || st_d == DATA;
    // flags follow the registered state, so load_done lands one cycle after the final strobe
    done_d = st_q == DONE && !start;
    err_d = st_q == ERROR && !start;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= LEN_LO;
      len_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q <= wr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign mem_addr = addr_q;
  assign mem_write = wr_q;
  assign mem_data_in = data_q;
  assign busy = busy_q;
  assign load_done = done_q;
  assign load_err = err_q;
endmodule
